// File: rtl/bus_copy_master_pkg.sv
// Shared definitions for the bus copy master: state encoding, bus geometry
// and the request payload that the master holds stable until accepted.
package bus_copy_master_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned RAM_MASK_WIDTH = DATA_W / 8;

  // Copy sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Everything the master presents alongside req_o
  typedef struct packed {
    logic                      we;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         data;
    logic [RAM_MASK_WIDTH-1:0] wem;
  } bus_req_t;

  // Next word address; wraps modulo 2^32
  function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/bus_copy_master.sv
// bus_copy_master: second bus initiator that copies len_i 32-bit words from
// src_addr_i to dst_addr_i as a forward, ascending copy, one read then one
// write per word, with at most one transaction outstanding.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               command strobe, honoured only when idle
//   src_addr_i/dst_addr_i word-aligned byte addresses (bits [1:0] ignored)
//   len_i                 number of words; zero completes with no bus traffic
//   busy_o                copy in progress (through the done cycle)
//   done_o / err_o        one-cycle completion pulse / timeout abort flag
//   req_o, we_o, addr_o,  request side of the req/addr_ok/data_ok bus,
//   data_o, wem_o         held stable until addr_ok_i
//   addr_ok_i, data_ok_i, responder accept, response valid and read data
//   data_i
module bus_copy_master
  import bus_copy_master_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255   // stall cycles tolerated, >= 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [ADDR_W-1:0]         src_addr_i,
  input  logic [ADDR_W-1:0]         dst_addr_i,
  input  logic [LEN_W-1:0]          len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      req_o,
  output logic                      we_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [DATA_W-1:0]         data_o,
  output logic [RAM_MASK_WIDTH-1:0] wem_o,
  input  logic                      addr_ok_i,
  input  logic                      data_ok_i,
  input  logic [DATA_W-1:0]         data_i
);

  localparam int unsigned TO_BITS = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (TO_BITS > 8) ? TO_BITS : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state;
  bus_req_t          bus_q;     // data field doubles as the word buffer
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [LEN_W-1:0]  remain;
  logic [CNT_W-1:0]  wd_cnt;

  logic progress;
  logic timeout;
  logic unused_addr_lsbs;

  // Request states advance on accept, wait states on response
  assign progress = ((state == ST_RD_REQ) || (state == ST_WR_REQ)) ? addr_ok_i : data_ok_i;
  // This stalled cycle is the TIMEOUT-th one without progress
  assign timeout  = (wd_cnt == TO_LAST);

  // Byte-offset bits of the command addresses carry no meaning
  assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  assign we_o   = bus_q.we;
  assign addr_o = bus_q.addr;
  assign data_o = bus_q.data;
  assign wem_o  = bus_q.wem;

  // Copy sequencer with registered bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bus_q   <= '0;
      cur_src <= '0;
      cur_dst <= '0;
      remain  <= '0;
      wd_cnt  <= '0;
      req_o   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (start_i) begin
            busy_o <= 1'b1;
            if (len_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              cur_src    <= {src_addr_i[ADDR_W-1:2], 2'b00};
              cur_dst    <= {dst_addr_i[ADDR_W-1:2], 2'b00};
              remain     <= len_i;
              bus_q.we   <= 1'b0;
              bus_q.addr <= {src_addr_i[ADDR_W-1:2], 2'b00};
              bus_q.wem  <= '0;
              req_o      <= 1'b1;
              state      <= ST_RD_REQ;
            end
          end
        end

        ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT: begin
          if (progress) begin
            wd_cnt <= '0;
            unique case (state)
              ST_RD_REQ: begin
                req_o <= 1'b0;
                state <= ST_RD_WAIT;
              end
              ST_RD_WAIT: begin
                bus_q.data <= data_i;
                bus_q.we   <= 1'b1;
                bus_q.addr <= cur_dst;
                bus_q.wem  <= '1;
                req_o      <= 1'b1;
                state      <= ST_WR_REQ;
              end
              ST_WR_REQ: begin
                req_o <= 1'b0;
                state <= ST_WR_WAIT;
              end
              default: begin  // ST_WR_WAIT: word complete
                cur_src   <= next_word_addr(cur_src);
                cur_dst   <= next_word_addr(cur_dst);
                remain    <= remain - LEN_W'(1);
                bus_q.we  <= 1'b0;
                bus_q.wem <= '0;
                if (remain == LEN_W'(1)) begin
                  done_o <= 1'b1;
                  state  <= ST_DONE;
                end else begin
                  bus_q.addr <= next_word_addr(cur_src);
                  req_o      <= 1'b1;
                  state      <= ST_RD_REQ;
                end
              end
            endcase
          end else if (timeout) begin
            // Abort: withdraw any pending request, remaining words are dropped
            wd_cnt    <= '0;
            req_o     <= 1'b0;
            bus_q.we  <= 1'b0;
            bus_q.wem <= '0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          req_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: a memory responder with configurable stalls and
// a transaction-level copy model that predicts every request, completion
// cycle and busy window; outputs are compared on every falling edge.
module tb_bus_copy_master;
  import bus_copy_master_pkg::*;

  localparam int unsigned LEN_W = 16;
  localparam int TO  = 8;
  localparam int BIG = 32'h7fff_ffff;

  logic                      clk, rst_n, start_i;
  logic [31:0]               src_addr_i, dst_addr_i;
  logic [LEN_W-1:0]          len_i;
  logic                      busy_o, done_o, err_o, req_o, we_o;
  logic [31:0]               addr_o, data_o, data_i;
  logic [RAM_MASK_WIDTH-1:0] wem_o;
  logic                      addr_ok_i, data_ok_i;

  bus_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .wem_o(wem_o),
    .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .data_i(data_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        log_q[$];
  txn_t        pend_t;
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] scratch [logic [31:0]];

  int cyc = 0, checks = 0, errors = 0;
  int busy_from = BIG, busy_to = BIG, exp_done = BIG, next_req = BIG;
  bit exp_err = 1'b0, pending = 1'b0;
  int acc_cyc = 0, pend_dly = 0, stall_cnt = 0, stall_target = 0;
  int stall_lo = 0, stall_hi = 0, dly_lo = 0, dly_hi = 0;
  bit no_addr = 1'b0, no_data = 1'b0, spurious = 1'b0;
  int done_seen = 0, err_seen = 0, last_done = 0, t_start = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ({a[15:0], a[31:16]} ^ 32'h5A5A_A5A5);
  endfunction

  function automatic logic [31:0] sc_rd(input logic [31:0] a);
    return scratch.exists(a) ? scratch[a] : mem_rd(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  // Responder: accepts after stall_target waiting cycles, answers after pend_dly
  task automatic respond();
    addr_ok_i = 1'b0;
    data_ok_i = 1'b0;
    data_i    = $urandom();
    if (pending && !no_data && cyc >= acc_cyc + 1 + pend_dly) begin
      data_ok_i = 1'b1;
      if (pend_t.we) mem[pend_t.addr] = pend_t.data;
      else           data_i = mem_rd(pend_t.addr);
      pending  = 1'b0;
      next_req = cyc + 1;
      if (exp_q.size() == 0) begin
        exp_done = cyc + 1;
        busy_to  = cyc + 1;
        exp_err  = 1'b0;
      end
    end else if (!pending && spurious && $urandom_range(0, 3) == 0) begin
      data_ok_i = 1'b1;
    end
    if (req_o && exp_q.size() > 0 && !pending && cyc >= next_req && cyc < exp_done) begin
      if (!no_addr && stall_cnt >= stall_target) begin
        addr_ok_i   = 1'b1;
        pend_t.we   = we_o;
        pend_t.addr = addr_o;
        pend_t.data = data_o;
        log_q.push_back(pend_t);
        void'(exp_q.pop_front());
        pending      = 1'b1;
        acc_cyc      = cyc;
        pend_dly     = $urandom_range(dly_lo, dly_hi);
        stall_cnt    = 0;
        stall_target = $urandom_range(stall_lo, stall_hi);
        if (no_data) begin
          exp_done = cyc + 1 + TO;
          busy_to  = exp_done;
          exp_err  = 1'b1;
        end
      end else begin
        stall_cnt++;
      end
    end
    if (no_addr && exp_q.size() > 0 && cyc == next_req && exp_done == BIG) begin
      exp_done = cyc + TO;
      busy_to  = exp_done;
      exp_err  = 1'b1;
    end
  endtask

  // One clock: compare outputs against the model, then drive the responder
  task automatic cycle();
    bit exp_req, exp_dn;
    @(negedge clk);
    cyc++;
    start_i = 1'b0;
    exp_req = (cyc >= next_req) && !pending && (exp_q.size() > 0) && (cyc < exp_done);
    exp_dn  = (cyc == exp_done);
    chk("req", 32'(req_o), 32'(exp_req));
    chk("done", 32'(done_o), 32'(exp_dn));
    chk("err", 32'(err_o), 32'(exp_dn && exp_err));
    chk("busy", 32'(busy_o), 32'(cyc >= busy_from && cyc <= busy_to));
    if (req_o && exp_req) begin
      chk("we", 32'(we_o), 32'(exp_q[0].we));
      chk("addr", addr_o, exp_q[0].addr);
      chk("wem", 32'(wem_o), exp_q[0].we ? 32'hF : 32'h0);
      if (exp_q[0].we) chk("wdata", data_o, exp_q[0].data);
    end
    if (done_o) begin
      done_seen++;
      last_done = cyc;
      if (err_o) err_seen++;
    end
    if (exp_dn) begin
      exp_q.delete();
      pending  = 1'b0;
      busy_to  = cyc;
      exp_done = BIG;
      next_req = BIG;
      exp_err  = 1'b0;
    end
    respond();
  endtask

  // Issue a command in the current cycle and build the expected transactions
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] s, d, v;
    start_i = 1'b1;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i = LEN_W'(len);
    t_start = cyc;
    busy_from = cyc + 1;
    busy_to = BIG;
    exp_done = BIG;
    exp_err = 1'b0;
    next_req = cyc + 1;
    pending = 1'b0;
    stall_cnt = 0;
    stall_target = $urandom_range(stall_lo, stall_hi);
    scratch.delete();
    exp_q.delete();
    log_q.delete();
    done_seen = 0;
    err_seen = 0;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++) begin
      v = sc_rd(s);
      exp_q.push_back('{we: 1'b0, addr: s, data: 32'h0});
      exp_q.push_back('{we: 1'b1, addr: d, data: v});
      scratch[d] = v;
      s = s + 32'd4;
      d = d + 32'd4;
    end
    if (len == 0) begin
      exp_done = cyc + 1;
      busy_to = cyc + 1;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(busy_to != BIG && cyc > busy_to)) begin
      cycle();
      n++;
      if (n > limit) begin
        checks++;
        errors++;
        $display("FAIL copy_completion @cyc %0d: still busy after %0d cycles", cyc, limit);
        break;
      end
    end
  endtask

  task automatic set_resp(input int slo, input int shi, input int dlo, input int dhi);
    stall_lo = slo; stall_hi = shi; dly_lo = dlo; dly_hi = dhi;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] src, dst;
    int len;
    rst_n = 1'b0; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    addr_ok_i = 1'b0; data_ok_i = 1'b0; data_i = '0;
    mem[32'h1000_0004] = 32'hDEADBEEF;

    repeat (2) cycle();
    chk("rst_req", 32'(req_o), 0);
    chk("rst_we", 32'(we_o), 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_wem", 32'(wem_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Single word, zero-wait responder
    set_resp(0, 0, 0, 0);
    start_copy(32'h1000_0004, 32'h2000_0000, 1);
    wait_idle(100);
    chk("t1_ntxn", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t1_rd_addr", log_q[0].addr, 32'h1000_0004);
      chk("t1_rd_we", 32'(log_q[0].we), 0);
      chk("t1_wr_addr", log_q[1].addr, 32'h2000_0000);
      chk("t1_wr_data", log_q[1].data, 32'hDEADBEEF);
    end
    chk("t1_latency", last_done - t_start, 5);
    chk("t1_ndone", done_seen, 1);
    chk("t1_nerr", err_seen, 0);
    chk("t1_mem", mem_rd(32'h2000_0000), 32'hDEADBEEF);

    // Three words, two stall cycles before every accept
    cycle();
    set_resp(2, 2, 0, 0);
    start_copy(32'h3000_0000, 32'h3000_0100, 3);
    wait_idle(200);
    chk("t2_ntxn", log_q.size(), 6);
    if (log_q.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        chk("t2_rd_addr", log_q[2*i].addr, 32'h3000_0000 + 32'(4*i));
        chk("t2_wr_addr", log_q[2*i+1].addr, 32'h3000_0100 + 32'(4*i));
      end
    end
    chk("t2_ndone", done_seen, 1);

    // Zero-length command
    cycle();
    set_resp(0, 0, 0, 0);
    start_copy(32'h3000_0000, 32'h3000_0100, 0);
    wait_idle(20);
    chk("t3_latency", last_done - t_start, 1);
    chk("t3_ntxn", log_q.size(), 0);
    chk("t3_ndone", done_seen, 1);

    // Source address wrap
    cycle();
    start_copy(32'hFFFF_FFFC, 32'h4000_0000, 2);
    wait_idle(100);
    chk("t4_ntxn", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t4_rd0", log_q[0].addr, 32'hFFFF_FFFC);
      chk("t4_rd1", log_q[2].addr, 32'h0000_0000);
      chk("t4_wr1", log_q[3].addr, 32'h4000_0004);
    end
    chk("t4_latency", last_done - t_start, 9);

    // Responder never answers: abort from the read wait
    cycle();
    no_data = 1'b1;
    start_copy(32'h5000_0000, 32'h5000_1000, 3);
    wait_idle(100);
    chk("t5_latency", last_done - t_start, 10);
    chk("t5_nerr", err_seen, 1);
    chk("t5_ntxn", log_q.size(), 1);
    no_data = 1'b0;

    // Responder never accepts: abort from the read request
    cycle();
    no_addr = 1'b1;
    start_copy(32'h5000_0000, 32'h5000_1000, 2);
    wait_idle(100);
    chk("t5b_latency", last_done - t_start, 9);
    chk("t5b_nerr", err_seen, 1);
    chk("t5b_ntxn", log_q.size(), 0);
    no_addr = 1'b0;

    // Randomised copies with stalls, delays, stray data_ok and overlap
    set_resp(0, 3, 0, 3);
    spurious = 1'b1;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(1, 3)) cycle();
      len = $urandom_range(0, 6);
      case ($urandom_range(0, 2))
        0: src = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1: src = 32'h0800_0000 + 32'($urandom_range(0, 255));
        default: src = $urandom();
      endcase
      if ($urandom_range(0, 1) == 1) dst = src + 32'(4 * $urandom_range(1, 3));
      else dst = $urandom();
      start_copy(src, dst, len);
      wait_idle(400);
      chk("rnd_ndone", done_seen, 1);
      chk("rnd_nerr", err_seen, 0);
      chk("rnd_ntxn", log_q.size(), 2 * len);
    end
    spurious = 1'b0;

    // Restart attempt mid-copy, then asynchronous reset
    set_resp(0, 0, 0, 0);
    cycle();
    start_copy(32'h6000_0000, 32'h6100_0000, 6);
    repeat (3) cycle();
    start_i = 1'b1;
    src_addr_i = 32'h0000_1000;
    dst_addr_i = 32'h0000_2000;
    len_i = LEN_W'(2);
    repeat (4) cycle();
    chk("t6_first_rd", log_q[0].addr, 32'h6000_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(req_o), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_done", 32'(done_o), 0);
    chk("t6_rst_err", 32'(err_o), 0);
    exp_q.delete();
    pending = 1'b0;
    busy_from = BIG; busy_to = BIG; exp_done = BIG; next_req = BIG;
    addr_ok_i = 1'b0; data_ok_i = 1'b0;
    done_seen = 0;
    repeat (2) cycle();
    chk("t6_no_done_in_rst", done_seen, 0);
    rst_n = 1'b1;
    cycle();
    start_copy(32'h1000_0004, 32'h7000_0000, 2);
    wait_idle(100);
    chk("t6_ndone", done_seen, 1);
    chk("t6_nerr", err_seen, 0);
    chk("t6_ntxn", log_q.size(), 4);
    chk("t6_latency", last_done - t_start, 9);
    chk("t6_mem", mem_rd(32'h7000_0000), 32'hDEADBEEF);
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
